// File: rtl/conv_out_writer.sv
// Convolution output writer: adds bias, applies ReLU, shift and saturation,
// then packs four result bytes per word and writes them to the output memory.
//
// state  | meaning
// IDLE   | waiting for i_run; run parameters latched on start
// RUN    | accepting results, packing bytes, issuing word writes
// DONE   | one-cycle completion pulse, then back to IDLE
module conv_out_writer #(
   parameter int AC_BW    = 21,
   parameter int BA_BW    = 21,
   parameter int DWIDTH   = 32,
   parameter int MEM_SIZE = 96,
   parameter int AW       = $clog2(MEM_SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_run,
   input  logic [BA_BW-1:0]  i_bias,
   input  logic [4:0]        i_shift,
   input  logic [9:0]        i_num_out,
   input  logic [AC_BW-1:0]  i_result,
   input  logic              i_valid,
   output logic              o_we,
   output logic [AW-1:0]     o_addr,
   output logic [DWIDTH-1:0] o_wdata,
   output logic              o_busy,
   output logic              o_done
);

   localparam int SW = ((AC_BW > BA_BW) ? AC_BW : BA_BW) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [BA_BW-1:0]  bias_q, bias_d;
   logic [4:0]        shift_q, shift_d;
   logic [9:0]        num_q, num_d;
   logic [9:0]        cnt_q, cnt_d;
   logic [1:0]        lane_q, lane_d;
   logic [DWIDTH-1:0] buf_q, buf_d;
   logic [AW-1:0]     ptr_q, ptr_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              fin_q, fin_d;

   logic signed [SW-1:0] sum;
   logic [SW-1:0]        v;
   logic [7:0]           res_byte;
   logic [DWIDTH-1:0]    word;
   logic                 last;

   // Both operands are sign-extended by at least one bit, so the add cannot overflow.
   always_comb begin
      sum      = $signed({{(SW-AC_BW){i_result[AC_BW-1]}}, i_result})
               + $signed({{(SW-BA_BW){bias_q[BA_BW-1]}}, bias_q});
      v        = $unsigned(sum) >> shift_q;
      res_byte = 8'd0;
      if (!sum[SW-1]) begin
         res_byte = (v > SW'(255)) ? 8'hFF : v[7:0];
      end
      word = buf_q;
      word[{lane_q, 3'b000} +: 8] = res_byte;
      last = ((cnt_q + 10'd1) == num_q);
   end

   always_comb begin
      state_d = state_q;
      bias_d  = bias_q;
      shift_d = shift_q;
      num_d   = num_q;
      cnt_d   = cnt_q;
      lane_d  = lane_q;
      buf_d   = buf_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      fin_d   = fin_q;
      case (state_q)
         S_IDLE: begin
            if (i_run) begin
               bias_d  = i_bias;
               shift_d = i_shift;
               num_d   = i_num_out;
               cnt_d   = '0;
               lane_d  = '0;
               buf_d   = '0;
               ptr_d   = '0;
               addr_d  = '0;
               fin_d   = 1'b0;
               state_d = (i_num_out != 10'd0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            // fin_q holds RUN for the cycle the final write is on the bus.
            if (fin_q) begin
               state_d = S_DONE;
            end else if (i_valid) begin
               cnt_d = cnt_q + 10'd1;
               if ((lane_q == 2'd3) || last) begin
                  we_d    = 1'b1;
                  wdata_d = word;
                  addr_d  = ptr_q;
                  ptr_d   = (ptr_q == AW'(MEM_SIZE-1)) ? '0 : ptr_q + 1'b1;
                  buf_d   = '0;
                  lane_d  = '0;
               end else begin
                  buf_d  = word;
                  lane_d = lane_q + 2'd1;
               end
               fin_d = last;
            end
         end
         S_DONE: begin
            fin_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         bias_q  <= '0;
         shift_q <= '0;
         num_q   <= '0;
         cnt_q   <= '0;
         lane_q  <= '0;
         buf_q   <= '0;
         ptr_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bias_q  <= bias_d;
         shift_q <= shift_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         lane_q  <= lane_d;
         buf_q   <= buf_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         fin_q   <= fin_d;
      end
   end

   assign o_we    = we_q;
   assign o_addr  = addr_q;
   assign o_wdata = wdata_q;
   assign o_busy  = (state_q == S_RUN);
   assign o_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_out_writer.sv
// Scoreboard bench for conv_out_writer: directed runs push expected writes,
// an independent monitor checks every write and completion pulse.
module tb_conv_out_writer;

   logic        clk;
   logic        rst;
   logic        i_run;
   logic [20:0] i_bias;
   logic [4:0]  i_shift;
   logic [9:0]  i_num_out;
   logic [20:0] i_result;
   logic        i_valid;
   logic        o_we;
   logic [6:0]  o_addr;
   logic [31:0] o_wdata;
   logic        o_busy;
   logic        o_done;

   typedef struct packed {
      logic [6:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  done_pending = 0;
   logic prev_we = 1'b0;
   logic prev_done = 1'b0;

   conv_out_writer dut (
      .clk       (clk),
      .rst       (rst),
      .i_run     (i_run),
      .i_bias    (i_bias),
      .i_shift   (i_shift),
      .i_num_out (i_num_out),
      .i_result  (i_result),
      .i_valid   (i_valid),
      .o_we      (o_we),
      .o_addr    (o_addr),
      .o_wdata   (o_wdata),
      .o_busy    (o_busy),
      .o_done    (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   task automatic expect_wr(input int addr, input logic [31:0] data);
      wr_t e;
      e.addr = 7'(addr);
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic start_run(input int bias, input int shift, input int num);
      i_bias    = 21'(bias);
      i_shift   = 5'(shift);
      i_num_out = 10'(num);
      i_run     = 1'b1;
      tick();
      i_run = 1'b0;
      check("busy_after_run", {31'd0, o_busy}, 32'd1);
   endtask

   task automatic send(input int val);
      i_result = 21'(val);
      i_valid  = 1'b1;
      tick();
      i_valid  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done_pending != 0 && n < 100) begin
         tick();
         n++;
      end
      if (done_pending != 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=pending required=done", name);
         done_pending = 0;
      end
      tick();
      tick();
   endtask

   // Monitor samples mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      if (rst) begin
         prev_we   <= 1'b0;
         prev_done <= 1'b0;
      end else begin
         if (o_we) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_we actual=addr %0d data 0x%08h required=no write", o_addr, o_wdata);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               if (o_addr !== e.addr || o_wdata !== e.data) begin
                  errors++;
                  $display("FAIL write actual=addr %0d data 0x%08h required=addr %0d data 0x%08h",
                           o_addr, o_wdata, e.addr, e.data);
               end
            end
         end
         if (o_done) begin
            checks++;
            if (!prev_we || done_pending == 0) begin
               errors++;
               $display("FAIL done_timing actual=prev_we %0b pending %0d required=prev_we 1 pending>0",
                        prev_we, done_pending);
            end
            if (done_pending > 0) done_pending--;
         end
         if (prev_done) begin
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0) begin
               errors++;
               $display("FAIL done_width actual=done %0b busy %0b required=0 0", o_done, o_busy);
            end
         end
         prev_we   <= o_we;
         prev_done <= o_done;
      end
   end

   initial begin
      rst = 1'b1; i_run = 1'b0; i_bias = '0; i_shift = '0; i_num_out = '0;
      i_result = '0; i_valid = 1'b0;
      tick(); tick();
      check("rst_we",    {31'd0, o_we},   32'd0);
      check("rst_addr",  {25'd0, o_addr}, 32'd0);
      check("rst_wdata", o_wdata,         32'd0);
      check("rst_busy",  {31'd0, o_busy}, 32'd0);
      check("rst_done",  {31'd0, o_done}, 32'd0);
      rst = 1'b0;
      tick();

      // simple packing
      expect_wr(0, 32'h04030201); done_pending++;
      start_run(0, 0, 4);
      send(1); send(2); send(3); send(4);
      wait_done("t1");

      // ReLU and saturation
      expect_wr(0, 32'hFF00FF00); done_pending++;
      start_run(-10, 0, 4);
      send(5); send(300); send(10); send(265);
      wait_done("t2");

      // shift, single result, partial word
      expect_wr(0, 32'h00000010); done_pending++;
      start_run(8, 4, 1);
      send(256);
      wait_done("t3");

      // back-to-back, partial last word
      expect_wr(0, 32'h04030201); expect_wr(1, 32'h00000605); done_pending++;
      start_run(0, 0, 6);
      i_valid = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         i_result = 21'(k);
         tick();
      end
      i_valid = 1'b0;
      wait_done("t4");

      // address wrap: 388 results, 97 words, word 96 lands at address 0
      for (int w = 0; w < 97; w++) begin
         logic [7:0] b;
         b = 8'(w);
         expect_wr(w % 96, {b ^ 8'h03, b ^ 8'h02, b ^ 8'h01, b});
      end
      done_pending++;
      start_run(0, 0, 388);
      i_valid = 1'b1;
      for (int w = 0; w < 97; w++) begin
         for (int k = 0; k < 4; k++) begin
            i_result = 21'((w & 255) ^ k);
            tick();
         end
      end
      i_valid = 1'b0;
      wait_done("t5");

      // reset mid-run aborts; rerun starts clean at address 0
      start_run(0, 0, 4);
      send(7); send(7);
      rst = 1'b1;
      tick();
      check("abort_we",   {31'd0, o_we},   32'd0);
      check("abort_busy", {31'd0, o_busy}, 32'd0);
      check("abort_addr", {25'd0, o_addr}, 32'd0);
      rst = 1'b0;
      repeat (5) tick();
      expect_wr(0, 32'h06070809); done_pending++;
      start_run(0, 0, 4);
      send(9); send(8); send(7); send(6);
      wait_done("t6");

      check("sb_empty", exp_q.size(), 32'd0);
      check("done_all", done_pending, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_out_writer.md
CONV_OUT_WRITER -- requirements
Module: conv_out_writer

Interface
REQ-001 SHALL have parameter AC_BW, default 21, meaning the width of the signed accumulator result consumed from top_data_mover.
REQ-002 SHALL have parameter BA_BW, default 21, meaning the width of the signed bias.
REQ-003 SHALL have parameter DWIDTH, default 32, meaning the output memory word width, packing 4 bytes per word.
REQ-004 SHALL have parameter MEM_SIZE, default 96, meaning the output memory depth in words.
REQ-005 SHALL have parameter AW, default $clog2(MEM_SIZE), meaning the address width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port i_run, input, 1 bit: start pulse, sampled in IDLE only.
REQ-009 SHALL have port i_bias, input, BA_BW bits: signed bias, latched on an accepted i_run.
REQ-010 SHALL have port i_shift, input, 5 bits: right-shift amount, latched on an accepted i_run.
REQ-011 SHALL have port i_num_out, input, 10 bits: number of results expected, latched on an accepted i_run.
REQ-012 SHALL have port i_result, input, AC_BW bits: signed result (connects to o_final_result).
REQ-013 SHALL have port i_valid, input, 1 bit: i_result qualifier (connects to o_final_valid).
REQ-014 SHALL have port o_we, output, 1 bit: memory write strobe.
REQ-015 SHALL have port o_addr, output, AW bits: write word address.
REQ-016 SHALL have port o_wdata, output, DWIDTH bits: packed write data.
REQ-017 SHALL have port o_busy, output, 1 bit: high while in RUN.
REQ-018 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.

Function
REQ-019 SHALL implement an FSM with states IDLE, RUN and DONE; DONE SHALL last exactly one cycle with o_done=1, then return to IDLE.
REQ-020 In IDLE, i_run=1 SHALL latch bias, shift and count, and clear the lane counter, address and byte buffer; the FSM SHALL go to RUN if i_num_out!=0, else directly to DONE with no write.
REQ-021 i_run SHALL be ignored in RUN and DONE; i_valid SHALL be ignored in IDLE and DONE.
REQ-022 Each accepted result SHALL be computed as sum = sext(i_result) + sext(bias), evaluated at max(AC_BW,BA_BW)+1 bits (22 bits), with no overflow possible.
REQ-023 If sum<0 the byte SHALL be 0 (ReLU); otherwise v = sum >> shift (truncating), and byte = (v>255) ? 255 : v[7:0].
REQ-024 Bytes SHALL fill lanes 0..3 in arrival order, with lane k occupying o_wdata[8k+7:8k].
REQ-025 A word SHALL be written when lane 3 fills or when the i_num_out-th result is accepted; unfilled lanes SHALL be 0.
REQ-026 o_we, o_addr and o_wdata SHALL be registered: o_we is high for exactly one cycle, the cycle after the edge that samples the completing i_valid.
REQ-027 o_addr SHALL start at 0 each run, increment after every write, and wrap from MEM_SIZE-1 to 0.
REQ-028 Back-to-back i_valid every cycle SHALL be accepted with no stall; a write SHALL coincide with acceptance of the next result without loss.
REQ-029 After the final result, the FSM SHALL enter DONE so that o_done is high in the cycle following the final o_we.
REQ-030 o_busy SHALL be 1 exactly while the state is RUN.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE and clear all counters, latched values and the byte buffer, and drive o_we=0, o_addr=0, o_wdata=0, o_busy=0 and o_done=0.
REQ-032 Reset asserted mid-run SHALL abort the run with no further write and no o_done; the next run SHALL start at address 0 and lane 0.

Verification
REQ-033 A bench SHALL verify: bias=0, shift=0, num=4, results 1,2,3,4 -> one write, addr 0, data 0x04030201, then o_done one cycle later.
REQ-034 A bench SHALL verify: bias=-10, shift=0, results 5,300,10,265 -> data 0xFF00FF00 (ReLU to 0, saturation to 255).
REQ-035 A bench SHALL verify: bias=8, shift=4, num=1, result 256 -> write addr 0, data 0x00000010, o_done.
REQ-036 A bench SHALL verify: num=6 with back-to-back valids 1..6 -> addr 0 = 0x04030201 and addr 1 = 0x00000605.
REQ-037 A bench SHALL verify: num=388 -> 97 writes, with addr 95 followed by addr 0, and o_done after the final write.
REQ-038 A bench SHALL verify: rst pulsed after 2 valids -> no o_we and no o_done; a rerun with num=4 writes at addr 0.
